// File: rtl/majority_seq_ctrl.sv
// majority_seq_ctrl
//   Takes one WORD_W-bit word through a valid/ready handshake and counts its
//   1 bits one CHUNK_W slice per cycle, starting at the LSB. It then reports
//   whether the word has more zeros, more ones, or an equal number of each.
//   The result is held until the consumer takes it.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   in_valid  producer offers in_data
//   in_ready  word can be accepted (high only in IDLE)
//   in_data   word to classify
//   out_valid result/ones/zeros valid, held until out_ready
//   out_ready consumer takes the result
//   result    2'b00 more zeros, 2'b01 more ones, 2'b10 equal
//   ones      number of 1 bits in the word
//   zeros     WORD_W - ones

// Counts the 1 bits in one slice of the word. This is the per-cycle datapath.
module majority_popcount #(
    parameter int CHUNK_W = 8,
    parameter int CNT_W   = 6
) (
    input  logic [CHUNK_W-1:0] chunk,
    output logic [CNT_W-1:0]   count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            count = count + CNT_W'(chunk[i]);
        end
    end
endmodule

module majority_seq_ctrl #(
    parameter int WORD_W  = 32,
    parameter int CHUNK_W = 8,   // WORD_W must be an integer multiple of CHUNK_W
    parameter int CNT_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        result,
    output logic [CNT_W-1:0]  ones,
    output logic [CNT_W-1:0]  zeros
);
    localparam int N     = WORD_W / CHUNK_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);

    localparam logic [1:0] RES_ZEROS = 2'b00;
    localparam logic [1:0] RES_ONES  = 2'b01;
    localparam logic [1:0] RES_TIE   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  shift;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   acc;
    logic [CNT_W-1:0]   chunk_cnt;
    logic [CNT_W-1:0]   acc_next;
    logic [CNT_W-1:0]   zeros_next;

    majority_popcount #(
        .CHUNK_W (CHUNK_W),
        .CNT_W   (CNT_W)
    ) u_popcount (
        .chunk (shift[CHUNK_W-1:0]),
        .count (chunk_cnt)
    );

    // The accumulator can hold WORD_W, so this sum cannot wrap.
    assign acc_next   = acc + chunk_cnt;
    assign zeros_next = WORD_CNT - acc_next;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            idx       <= '0;
            acc       <= '0;
            ones      <= '0;
            zeros     <= '0;
            result    <= RES_ZEROS;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift <= in_data;
                        acc   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    shift <= shift >> CHUNK_W;
                    idx   <= idx + 1'b1;
                    // Load the outputs directly from the final sum. This makes
                    // out_valid rise on the same edge that adds the last chunk.
                    if (idx == LAST_IDX) begin
                        ones      <= acc_next;
                        zeros     <= zeros_next;
                        result    <= (acc_next < zeros_next) ? RES_ZEROS :
                                     (acc_next > zeros_next) ? RES_ONES  : RES_TIE;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // ones/zeros/result keep their values after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_majority_seq_ctrl.sv
module tb_majority_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data;
    logic [1:0]  result;
    logic [5:0]  ones, zeros;

    // Second instance for the WORD_W == CHUNK_W corner case.
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]  s_in_data;
    logic [1:0]  s_result;
    logic [3:0]  s_ones, s_zeros;

    always #5 clk = ~clk;

    majority_seq_ctrl #(.WORD_W(32), .CHUNK_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ones(ones), .zeros(zeros)
    );

    majority_seq_ctrl #(.WORD_W(8), .CHUNK_W(8)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .ones(s_ones), .zeros(s_zeros)
    );

    typedef struct {
        int ones;
        int zeros;
        int result;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [31:0] w, input int width, input int lat);
        exp_t e;
        e.ones = 0;
        for (int i = 0; i < width; i++) e.ones += int'(w[i]);
        e.zeros  = width - e.ones;
        e.result = (e.ones < e.zeros) ? 0 : (e.ones > e.zeros) ? 1 : 2;
        e.lat    = lat;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word. Check latency and values against the scoreboard.
    // Stall the consumer for `hold` cycles, then complete the output handshake.
    task automatic run_word(input logic [31:0] w, input int hold, input bit chk_gap);
        exp_t e;
        int   t, c0;
        sb.push_back(model(w, 32, 4));
        t = 0;
        while (!in_ready && t < 50) begin tick(); t++; end
        chk("in_ready_idle", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        c0 = cyc + 1;
        #1;
        in_valid = 1'b0;
        if (chk_gap) chk("accept_gap", c0 - last_valid_cyc, 2);
        t = 0;
        while (!out_valid && t < 20) begin tick(); t++; end
        last_valid_cyc = cyc;
        e = sb.pop_front();
        chk("out_valid_rise", int'(out_valid), 1);
        chk("latency", cyc - c0, e.lat);
        chk("ones", int'(ones), e.ones);
        chk("zeros", int'(zeros), e.zeros);
        chk("result", int'(result), e.result);
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;      // must be ignored while DONE
            in_data   = ~w;
            out_ready = 1'b0;
            tick();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_ones", int'(ones), e.ones);
            chk("hold_result", int'(result), e.result);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_fall", int'(out_valid), 0);
        chk("ones_kept", int'(ones), e.ones);
        chk("result_kept", int'(result), e.result);
    endtask

    initial begin
        exp_t e;
        int   t, c0;
        bit   seen;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_ones", int'(ones), 0);
        chk("rst_zeros", int'(zeros), 0);
        chk("rst_result", int'(result), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_word(32'h0000_0000, 0, 1'b0);
        run_word(32'hFFFF_FFFF, 0, 1'b0);
        run_word(32'h0000_FFFF, 0, 1'b0);
        run_word(32'hA5A5_A5A5, 0, 1'b1);
        run_word(32'h8000_0001, 3, 1'b0);

        // Abort a word mid-run with an asynchronous reset.
        in_valid = 1'b1; in_data = 32'h0000_00FF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_ones", int'(ones), 0);
        chk("abort_zeros", int'(zeros), 0);
        chk("abort_result", int'(result), 0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", int'(seen), 0);
        chk("abort_ones_after", int'(ones), 0);
        run_word(32'hFFFF_FF00, 0, 1'b0);

        // WORD_W == CHUNK_W: a single chunk, so the latency is one cycle.
        e = model(32'h0000_000F, 8, 1);
        sb.push_back(e);
        s_in_valid = 1'b1; s_in_data = 8'h0F;
        @(posedge clk);
        c0 = cyc + 1;
        #1;
        s_in_valid = 1'b0;
        t = 0;
        while (!s_out_valid && t < 20) begin tick(); t++; end
        e = sb.pop_front();
        chk("s_latency", cyc - c0, e.lat);
        chk("s_ones", int'(s_ones), e.ones);
        chk("s_zeros", int'(s_zeros), e.zeros);
        chk("s_result", int'(s_result), e.result);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("s_valid_fall", int'(s_out_valid), 0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
